// File: rtl/cp0_timer_multi_pkg.sv
// Shared constants for the multi-channel CP0 count/compare timer:
// register map, CTRL field positions and enable encodings.
package cp0_timer_multi_pkg;

   localparam int TMR_COUNT   = 0;
   localparam int TMR_CTRL    = 1;
   localparam int TMR_STATUS  = 2;
   localparam int TMR_IMASK   = 3;
   localparam int TMR_CH_BASE = 8;

   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_PSC_LSB = 8;

   localparam logic TIMER_ENABLE  = 1'b1;
   localparam logic TIMER_DISABLE = 1'b0;

   // Each channel owns an adjacent COMPARE/PERIOD address pair
   function automatic int ch_cmp_addr(input int k);
      return TMR_CH_BASE + 2 * k;
   endfunction

   function automatic int ch_per_addr(input int k);
      return TMR_CH_BASE + 2 * k + 1;
   endfunction

endpackage

// File: rtl/cp0_timer_ch.sv
// One compare channel: COMPARE, PERIOD and sticky pending bit, with
// optional auto-advance of COMPARE by PERIOD on every match.
module cp0_timer_ch #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              match_en,
   input  logic [DATA_W-1:0] count_next,
   input  logic              cmp_we,
   input  logic              per_we,
   input  logic [DATA_W-1:0] wdata,
   input  logic              w1c,
   output logic [DATA_W-1:0] compare,
   output logic [DATA_W-1:0] period,
   output logic              pending
);

   logic [DATA_W-1:0] compare_r;
   logic [DATA_W-1:0] period_r;
   logic              pending_r;
   logic              match_s;

   assign match_s = match_en && (count_next == compare_r);

   // COMPARE: software write beats the periodic auto-advance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         compare_r <= {DATA_W{1'b0}};
      end else if (cmp_we) begin
         compare_r <= wdata;
      end else if (match_s && (period_r != {DATA_W{1'b0}})) begin
         compare_r <= compare_r + period_r;
      end
   end

   // PERIOD: plain load, zero selects one-shot mode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_r <= {DATA_W{1'b0}};
      end else if (per_we) begin
         period_r <= wdata;
      end
   end

   // Pending: COMPARE write clears, a match sets, and a set beats W1C
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_r <= 1'b0;
      end else if (cmp_we) begin
         pending_r <= 1'b0;
      end else if (match_s) begin
         pending_r <= 1'b1;
      end else if (w1c) begin
         pending_r <= 1'b0;
      end
   end

   assign compare = compare_r;
   assign period  = period_r;
   assign pending = pending_r;

endmodule

// File: rtl/cp0_timer_multi.sv
// CP0 free-running COUNT with prescaler, NUM_CH compare channels,
// overflow sticky bit, interrupt masking and the mfc0 read mux.
module cp0_timer_multi
   import cp0_timer_multi_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int NUM_CH     = 2,
   parameter int PRESCALE_W = 8,
   parameter int ADDR_W     = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] data_o,
   output logic [NUM_CH-1:0] timer_int_o,
   output logic              irq_any_o
);

   logic [DATA_W-1:0]     count_r;
   logic [PRESCALE_W-1:0] psc_cnt_r;
   logic                  en_r;
   logic [PRESCALE_W-1:0] psc_r;
   logic [NUM_CH-1:0]     imask_r;
   logic                  ovf_r;

   logic                  tick_s;
   logic                  count_we_s;
   logic                  ctrl_we_s;
   logic                  status_we_s;
   logic                  imask_we_s;
   logic                  match_en_s;
   logic                  ovf_set_s;
   logic [DATA_W-1:0]     count_next_s;
   logic [NUM_CH-1:0]     w1c_s;
   logic [NUM_CH-1:0]     ch_pending_s;
   logic [NUM_CH-1:0]     ch_cmp_we_s;
   logic [NUM_CH-1:0]     ch_per_we_s;
   logic [DATA_W-1:0]     ch_compare_s [NUM_CH];
   logic [DATA_W-1:0]     ch_period_s  [NUM_CH];
   logic [DATA_W-1:0]     ch_rdata_s;
   logic [DATA_W-1:0]     rdata_s;

   assign count_we_s  = we_i && (waddr_i == ADDR_W'(TMR_COUNT));
   assign ctrl_we_s   = we_i && (waddr_i == ADDR_W'(TMR_CTRL));
   assign status_we_s = we_i && (waddr_i == ADDR_W'(TMR_STATUS));
   assign imask_we_s  = we_i && (waddr_i == ADDR_W'(TMR_IMASK));

   assign tick_s       = (en_r == TIMER_ENABLE) && (psc_cnt_r == psc_r);
   assign count_next_s = count_r + {{(DATA_W-1){1'b0}}, 1'b1};
   // A COUNT write suppresses both the increment and match evaluation
   assign match_en_s   = tick_s && !count_we_s;
   assign ovf_set_s    = match_en_s && (count_r == {DATA_W{1'b1}});
   assign w1c_s        = status_we_s ? data_i[NUM_CH-1:0] : {NUM_CH{1'b0}};

   // Prescaler and COUNT; a COUNT write also restarts the prescaler
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r   <= {DATA_W{1'b0}};
         psc_cnt_r <= {PRESCALE_W{1'b0}};
      end else if (count_we_s) begin
         count_r   <= data_i;
         psc_cnt_r <= {PRESCALE_W{1'b0}};
      end else if (en_r == TIMER_ENABLE) begin
         if (tick_s) begin
            count_r   <= count_next_s;
            psc_cnt_r <= {PRESCALE_W{1'b0}};
         end else begin
            psc_cnt_r <= psc_cnt_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // CTRL and IMASK registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_r    <= TIMER_DISABLE;
         psc_r   <= {PRESCALE_W{1'b0}};
         imask_r <= {NUM_CH{1'b0}};
      end else begin
         if (ctrl_we_s) begin
            en_r  <= data_i[CTRL_EN_BIT];
            psc_r <= data_i[CTRL_PSC_LSB +: PRESCALE_W];
         end
         if (imask_we_s) begin
            imask_r <= data_i[NUM_CH-1:0];
         end
      end
   end

   // Overflow sticky bit; a wrap in the same cycle beats the W1C
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_r <= 1'b0;
      end else if (ovf_set_s) begin
         ovf_r <= 1'b1;
      end else if (status_we_s && data_i[NUM_CH]) begin
         ovf_r <= 1'b0;
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign ch_cmp_we_s[k] = we_i && (waddr_i == ADDR_W'(ch_cmp_addr(k)));
      assign ch_per_we_s[k] = we_i && (waddr_i == ADDR_W'(ch_per_addr(k)));

      cp0_timer_ch #(
         .DATA_W (DATA_W)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .match_en   (match_en_s),
         .count_next (count_next_s),
         .cmp_we     (ch_cmp_we_s[k]),
         .per_we     (ch_per_we_s[k]),
         .wdata      (data_i),
         .w1c        (w1c_s[k]),
         .compare    (ch_compare_s[k]),
         .period     (ch_period_s[k]),
         .pending    (ch_pending_s[k])
      );
   end

   // Channel register read: at most one address hits, so OR-reduce
   always_comb begin
      ch_rdata_s = {DATA_W{1'b0}};
      for (int k = 0; k < NUM_CH; k++) begin
         ch_rdata_s = ch_rdata_s
                    | ((raddr_i == ADDR_W'(ch_cmp_addr(k))) ? ch_compare_s[k] : {DATA_W{1'b0}})
                    | ((raddr_i == ADDR_W'(ch_per_addr(k))) ? ch_period_s[k]  : {DATA_W{1'b0}});
      end
   end

   // mfc0 read mux, pre-write contents only
   always_comb begin
      rdata_s = {DATA_W{1'b0}};
      case (raddr_i)
         ADDR_W'(TMR_COUNT):  rdata_s = count_r;
         ADDR_W'(TMR_CTRL):   rdata_s = DATA_W'({psc_r, 7'b0000000, en_r});
         ADDR_W'(TMR_STATUS): rdata_s = DATA_W'({ovf_r, ch_pending_s});
         ADDR_W'(TMR_IMASK):  rdata_s = DATA_W'(imask_r);
         default:             rdata_s = ch_rdata_s;
      endcase
   end

   assign data_o      = rdata_s;
   assign timer_int_o = ch_pending_s & imask_r;
   assign irq_any_o   = |timer_int_o;

endmodule

// File: tb/tb_cp0_timer_multi.sv
// Directed bench for cp0_timer_multi (DATA_W=32, NUM_CH=2, PRESCALE_W=8).
// Inputs change just after the falling edge; outputs are sampled in the low phase.
module tb_cp0_timer_multi;

   logic        clk;
   logic        rst;
   logic        we_i;
   logic [4:0]  waddr_i;
   logic [31:0] data_i;
   logic [4:0]  raddr_i;
   logic [31:0] data_o;
   logic [1:0]  timer_int_o;
   logic        irq_any_o;

   int total;
   int passed;
   int failed;

   cp0_timer_multi #(
      .DATA_W     (32),
      .NUM_CH     (2),
      .PRESCALE_W (8),
      .ADDR_W     (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .we_i        (we_i),
      .waddr_i     (waddr_i),
      .data_i      (data_i),
      .raddr_i     (raddr_i),
      .data_o      (data_o),
      .timer_int_o (timer_int_o),
      .irq_any_o   (irq_any_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
      raddr_i = addr;
      #1;
      chk(tag, data_o, exp);
   endtask

   // Drive one write so it lands on the next rising edge; returns at the falling edge after it
   task automatic wr(input logic [4:0] addr, input logic [31:0] d);
      we_i    = 1'b1;
      waddr_i = addr;
      data_i  = d;
      @(negedge clk);
      we_i    = 1'b0;
      waddr_i = 5'd0;
      data_i  = 32'd0;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      total   = 0;
      passed  = 0;
      failed  = 0;
      rst     = 1'b1;
      we_i    = 1'b0;
      waddr_i = 5'd0;
      data_i  = 32'd0;
      raddr_i = 5'd0;

      @(negedge clk);
      rd_chk("rst_count", 5'd0, 32'd0);
      chk("rst_int", {30'd0, timer_int_o}, 32'd0);
      chk("rst_irq", {31'd0, irq_any_o}, 32'd0);
      rst = 1'b0;

      // Basic one-shot match with PSC=0
      wr(5'd8, 32'd5);
      wr(5'd3, 32'd1);
      wr(5'd1, 32'd1);
      repeat (4) step();
      rd_chk("t1_count4", 5'd0, 32'd4);
      chk("t1_int_before", {30'd0, timer_int_o}, 32'd0);
      step();
      rd_chk("t1_count5", 5'd0, 32'd5);
      chk("t1_int_match", {30'd0, timer_int_o}, 32'd1);
      chk("t1_irq_match", {31'd0, irq_any_o}, 32'd1);
      rd_chk("t1_status", 5'd2, 32'd1);
      step();
      rd_chk("t1_cmp_oneshot", 5'd8, 32'd5);
      wr(5'd1, 32'd0);
      wr(5'd2, 32'd1);
      rd_chk("t1_status_clr", 5'd2, 32'd0);
      chk("t1_irq_clr", {31'd0, irq_any_o}, 32'd0);
      step();
      rd_chk("t1_frozen", 5'd0, 32'd7);

      // Prescaler PSC=3
      wr(5'd0, 32'd0);
      wr(5'd1, 32'h0000_0301);
      repeat (3) step();
      rd_chk("t2_psc_3cyc", 5'd0, 32'd0);
      step();
      rd_chk("t2_psc_4cyc", 5'd0, 32'd1);
      repeat (4) step();
      rd_chk("t2_psc_8cyc", 5'd0, 32'd2);
      wr(5'd1, 32'h0000_0300);
      repeat (5) step();
      rd_chk("t2_en0_freeze", 5'd0, 32'd2);
      rd_chk("t2_ctrl_rd", 5'd1, 32'h0000_0300);
      wr(5'd1, 32'hFFFF_FFFF);
      rd_chk("t2_ctrl_mask", 5'd1, 32'h0000_FF01);
      wr(5'd1, 32'd0);
      wr(5'd3, 32'h0000_00FF);
      rd_chk("t2_imask_mask", 5'd3, 32'd3);

      // Periodic channel 1
      wr(5'd11, 32'd10);
      wr(5'd10, 32'd4);
      wr(5'd3, 32'd2);
      wr(5'd0, 32'd0);
      wr(5'd1, 32'd1);
      repeat (3) step();
      rd_chk("t3_count3", 5'd0, 32'd3);
      chk("t3_int_before", {30'd0, timer_int_o}, 32'd0);
      step();
      chk("t3_int_ch1", {30'd0, timer_int_o}, 32'd2);
      rd_chk("t3_cmp1_adv", 5'd10, 32'd14);
      rd_chk("t3_per1", 5'd11, 32'd10);
      wr(5'd2, 32'd2);
      rd_chk("t3_status_w1c", 5'd2, 32'd1);
      chk("t3_int_clr", {30'd0, timer_int_o}, 32'd0);
      repeat (8) step();
      rd_chk("t3_count13", 5'd0, 32'd13);
      chk("t3_int_13", {30'd0, timer_int_o}, 32'd0);
      step();
      chk("t3_int_refire", {30'd0, timer_int_o}, 32'd2);
      rd_chk("t3_cmp1_adv2", 5'd10, 32'd24);
      wr(5'd1, 32'd0);
      wr(5'd2, 32'd3);
      rd_chk("t3_status_clr", 5'd2, 32'd0);

      // Write collisions with a match
      wr(5'd8, 32'd20);
      wr(5'd0, 32'd19);
      wr(5'd1, 32'd1);
      wr(5'd8, 32'd77);
      rd_chk("t4_cmpwr_nopend", 5'd2, 32'd0);
      rd_chk("t4_cmpwr_value", 5'd8, 32'd77);
      rd_chk("t4_count20", 5'd0, 32'd20);
      repeat (3) step();
      wr(5'd2, 32'd2);
      rd_chk("t4_w1c_loses", 5'd2, 32'd2);
      rd_chk("t4_cmp1_adv", 5'd10, 32'd34);
      chk("t4_int", {30'd0, timer_int_o}, 32'd2);
      wr(5'd1, 32'd0);
      wr(5'd2, 32'd3);

      // COUNT wrap and overflow
      wr(5'd0, 32'hFFFF_FFFE);
      wr(5'd1, 32'd1);
      step();
      rd_chk("t5_count_ff", 5'd0, 32'hFFFF_FFFF);
      rd_chk("t5_no_ovf", 5'd2, 32'd0);
      step();
      rd_chk("t5_wrap", 5'd0, 32'd0);
      rd_chk("t5_ovf", 5'd2, 32'd4);
      wr(5'd2, 32'd4);
      rd_chk("t5_ovf_clr", 5'd2, 32'd0);
      rd_chk("t5_count1", 5'd0, 32'd1);
      wr(5'd0, 32'd1000);
      rd_chk("t5_cntwr_tick", 5'd0, 32'd1000);
      step();
      rd_chk("t5_cnt_resume", 5'd0, 32'd1001);

      // Asynchronous reset with a pending interrupt
      wr(5'd1, 32'd0);
      wr(5'd8, 32'd100);
      wr(5'd0, 32'd99);
      wr(5'd3, 32'd1);
      wr(5'd1, 32'd1);
      step();
      rd_chk("t6_count100", 5'd0, 32'd100);
      chk("t6_int_pre", {30'd0, timer_int_o}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("t6_rst_int", {30'd0, timer_int_o}, 32'd0);
      chk("t6_rst_irq", {31'd0, irq_any_o}, 32'd0);
      rd_chk("t6_rst_count", 5'd0, 32'd0);
      rd_chk("t6_rst_status", 5'd2, 32'd0);
      rd_chk("t6_rst_cmp0", 5'd8, 32'd0);
      rd_chk("t6_rst_ctrl", 5'd1, 32'd0);
      rd_chk("t6_rst_imask", 5'd3, 32'd0);
      rd_chk("t6_rst_per1", 5'd11, 32'd0);
      rst = 1'b0;
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/cp0_timer_multi.md
Name: cp0_timer_multi

Overview:
- Parametrised successor to the single-compare CP0 count/compare timer.
- Free-running COUNT with programmable prescaler, plus NUM_CH independent compare channels.
- Each channel has a one-shot or auto-reload periodic mode, a sticky pending bit and a maskable interrupt line.
- Written from the WB stage through the CP0 write port; read combinationally by EX for mfc0; interrupt lines feed the CP0 Cause IP bits / int_i.

Parameters:
DATA_W, 32, width of COUNT, COMPARE and PERIOD registers and of the data bus
NUM_CH, 2, number of compare channels (1..8)
PRESCALE_W, 8, width of prescale divisor field
ADDR_W, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
we_i  in  1  register write enable (from WB stage)
waddr_i  in  ADDR_W  write address
data_i  in  DATA_W  write data
raddr_i  in  ADDR_W  read address
data_o  out  DATA_W  read data, combinational from raddr_i
timer_int_o  out  NUM_CH  per-channel interrupt, pending & mask
irq_any_o  out  1  OR of timer_int_o

Behaviour:
- Reset (async, rst=1):
  - COUNT=0, CTRL=0 (disabled, prescale 0), IMASK=0, STATUS=0, all COMPARE=0, all PERIOD=0, prescale counter=0.
  - timer_int_o=0, irq_any_o=0.
- Register map (unmapped addresses read 0, writes ignored):
  - 0 COUNT.
  - 1 CTRL: bit0 EN; bits[8+PRESCALE_W-1:8] PSC.
  - 2 STATUS: bits[NUM_CH-1:0] pending; bit NUM_CH overflow; write-1-to-clear.
  - 3 IMASK: bits[NUM_CH-1:0].
  - 8+2k COMPARE[k].
  - 9+2k PERIOD[k].
- Prescaler:
  - When EN=1, the prescale counter counts 0..PSC.
  - tick=1 in a cycle where the counter equals PSC; the counter then returns to 0.
  - PSC=0 gives tick every cycle.
  - EN=0 holds both the prescale counter and COUNT.
- COUNT:
  - On tick, COUNT <= COUNT+1 modulo 2^DATA_W.
  - Wrap from all-ones to 0 sets the overflow sticky bit.
- Match, channel k: at the edge where tick=1 and COUNT+1 == COMPARE[k]:
  - pending[k] <= 1, visible the same cycle COUNT shows the matched value.
  - If PERIOD[k] != 0, COMPARE[k] <= COMPARE[k]+PERIOD[k], modulo 2^DATA_W (periodic mode).
  - If PERIOD[k] == 0, COMPARE[k] is unchanged (one-shot; re-fires after COUNT wraps).
- Write side effects (one write per cycle, takes effect at the next edge):
  - COUNT write loads data_i and clears the prescale counter to 0; it wins over tick in the same cycle; no match is evaluated that cycle.
  - COMPARE[k] write loads data_i and clears pending[k]; it wins over a simultaneous match (no set, no auto-advance).
  - STATUS write clears the bits written 1; a simultaneous match set or overflow set wins over the clear.
  - CTRL, IMASK and PERIOD writes: plain load, masked to field width.
- Outputs:
  - timer_int_o = pending & IMASK, combinational from flops.
  - data_o shows pre-write register contents; no write-to-read bypass. EX-stage forwarding from MEM/WB CP0 writes is handled upstream.
- Reset mid-count aborts everything immediately; no pending survives.

Decomposition:
- Shared include (macro.v): register address constants (TMR_COUNT, TMR_CTRL, TMR_STATUS, TMR_IMASK, TMR_CH_BASE), CTRL field positions, and the TimerEnable/TimerDisable constants.
- Sub-module cp0_timer_ch: holds COMPARE, PERIOD and pending for one channel.
  - Inputs: tick, count_next, write strobes, w1c bit.
  - Outputs: compare, period, pending.
  - Instantiated NUM_CH times in a generate loop.
- Top module holds the prescaler, COUNT, CTRL, IMASK, overflow, and the read mux.

Test Plan:
- Reset, then write CTRL=1 (PSC=0), COMPARE[0]=5, IMASK=1 → COUNT increments every cycle; pending[0] and timer_int_o[0] go 1 on the edge where COUNT becomes 5; irq_any_o=1.
- PSC=3, EN=1, from COUNT=0 → COUNT increments every 4th cycle; COUNT=2 after 8 cycles post-enable; EN=0 freezes COUNT.
- PERIOD[1]=10, COMPARE[1]=4, IMASK=2 → pending[1] sets at COUNT=4; COMPARE[1] reads 14; after STATUS write 0x2 clears it, pending sets again at COUNT=14.
- COMPARE[0] write in the same cycle as a match → pending[0] stays 0 and COMPARE[0] holds the written value; STATUS W1C in the same cycle as a match → pending stays 1.
- COUNT written 0xFFFFFFFE, EN=1, PSC=0 → COUNT wraps to 0 after 2 cycles; STATUS bit NUM_CH=1; COUNT write during a tick loads the written value exactly.
- Assert rst while pending[0]=1 and COUNT=100 → all registers, timer_int_o and data_o read 0 immediately (asynchronously).
